// File: rtl/motor_feedback_decoder_pkg.sv
// Shared quadrature constants and the step classifier used by the hall feedback decoder.
package motor_feedback_decoder_pkg;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;
  localparam logic       DIR_FWD = 1'b1;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00; a two-bit change is illegal.
  function automatic step_t classify(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s = STEP_NONE;
    case ({prev, cur})
      {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: s = STEP_FWD;
      {Q00, Q10}, {Q10, Q11}, {Q11, Q01}, {Q01, Q00}: s = STEP_REV;
      default: s = ((prev ^ cur) == 2'b11) ? STEP_ERR : STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/motor_feedback_decoder_hall_input_filter.sv
// One hall pin: 2-FF synchroniser followed by a FILT_CYC-sample stability filter.
module hall_input_filter #(
  parameter int FILT_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic filt
);

  localparam int CW = $clog2(FILT_CYC + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronised samples that disagree with filt.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      filt <= 1'b0;
      cnt  <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_CYC - 1)) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/motor_feedback_decoder.sv
// Hall feedback for one motor: filtered quadrature decode into position, direction and speed.
module motor_feedback_decoder
  import motor_feedback_decoder_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SAMPLE_HZ = 10,
  parameter int POS_W     = 32,
  parameter int SPD_W     = 16,
  parameter int FILT_CYC  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sa,
  input  logic             sb,
  input  logic             clear,
  output logic [POS_W-1:0] position,
  output logic             dir,
  output logic [SPD_W-1:0] speed,
  output logic             speed_valid,
  output logic             edge_err
);

  localparam int WIN = CLK_HZ / SAMPLE_HZ;
  localparam int WW  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [SPD_W-1:0] SPD_ONE = SPD_W'(1);
  localparam logic [SPD_W-1:0] SPD_MAX = '1;

  logic             a;
  logic             b;
  logic [1:0]       prev;
  logic             init_done;
  logic [WW-1:0]    win_cnt;
  logic [SPD_W-1:0] edge_cnt;
  logic [SPD_W-1:0] edge_next;
  step_t            step;
  logic             accepted;

  hall_input_filter #(.FILT_CYC(FILT_CYC)) u_filt_a (
    .clk(clk), .reset(reset), .pin(sa), .filt(a)
  );

  hall_input_filter #(.FILT_CYC(FILT_CYC)) u_filt_b (
    .clk(clk), .reset(reset), .pin(sb), .filt(b)
  );

  // Until prev has been loaded once, nothing is decoded.
  assign step     = init_done ? classify(prev, {a, b}) : STEP_NONE;
  assign accepted = (step == STEP_FWD) || (step == STEP_REV);

  always_comb begin
    edge_next = edge_cnt;
    if (accepted && (edge_cnt != SPD_MAX)) edge_next = edge_cnt + SPD_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev        <= Q00;
      init_done   <= 1'b0;
      position    <= '0;
      dir         <= DIR_FWD;
      speed       <= '0;
      speed_valid <= 1'b0;
      edge_err    <= 1'b0;
      win_cnt     <= '0;
      edge_cnt    <= '0;
    end else begin
      prev      <= {a, b};
      init_done <= 1'b1;
      edge_err  <= (step == STEP_ERR);

      if (clear)                  position <= '0;
      else if (step == STEP_FWD)  position <= position + POS_ONE;
      else if (step == STEP_REV)  position <= position - POS_ONE;

      if (step == STEP_FWD)       dir <= DIR_FWD;
      else if (step == STEP_REV)  dir <= ~DIR_FWD;

      // The terminal cycle reports the count including an edge accepted in that cycle.
      if (win_cnt == WW'(WIN - 1)) begin
        win_cnt     <= '0;
        speed       <= edge_next;
        speed_valid <= 1'b1;
        edge_cnt    <= '0;
      end else begin
        win_cnt     <= win_cnt + WW'(1);
        speed_valid <= 1'b0;
        edge_cnt    <= edge_next;
      end
    end
  end

endmodule

// File: tb/tb_motor_feedback_decoder.sv
// Directed-plus-random bench for motor_feedback_decoder with a quadrature/window reference model.
module tb_motor_feedback_decoder;
  import motor_feedback_decoder_pkg::*;

  localparam int CLK_HZ    = 1000;
  localparam int SAMPLE_HZ = 10;
  localparam int FILT      = 4;
  localparam int WIN       = CLK_HZ / SAMPLE_HZ;
  localparam int LAT       = 2 + FILT + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sa = 1'b0, sb = 1'b0, clear = 1'b0;
  logic [31:0] position;
  logic        dir;
  logic [15:0] speed;
  logic        speed_valid, edge_err;

  logic        sa4 = 1'b0, sb4 = 1'b0, clear4 = 1'b0;
  logic [3:0]  position4;
  logic        dir4;
  logic [15:0] speed4;
  logic        speed_valid4, edge_err4;

  always #5 clk = ~clk;

  motor_feedback_decoder #(
    .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .POS_W(32), .SPD_W(16), .FILT_CYC(FILT)
  ) dut (
    .clk(clk), .reset(reset), .sa(sa), .sb(sb), .clear(clear),
    .position(position), .dir(dir), .speed(speed),
    .speed_valid(speed_valid), .edge_err(edge_err)
  );

  motor_feedback_decoder #(
    .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .POS_W(4), .SPD_W(16), .FILT_CYC(FILT)
  ) dut4 (
    .clk(clk), .reset(reset), .sa(sa4), .sb(sb4), .clear(clear4),
    .position(position4), .dir(dir4), .speed(speed4),
    .speed_valid(speed_valid4), .edge_err(edge_err4)
  );

  int checks = 0;
  int errors = 0;
  int n = 0;
  bit mon_on = 1'b0;
  int err_cnt = 0;
  int win_edges [int];
  int model_pos = 0;
  bit model_dir = 1'b1;
  int phase = 0;
  int phase4 = 0;
  logic [1:0] gray [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Posedges since reset release; the k-th one is window cycle (k-1)%WIN.
  always @(posedge clk) n <= reset ? 0 : n + 1;

  always @(negedge clk) begin
    int w, e;
    bit expv;
    if (mon_on) begin
      if (edge_err === 1'b1) err_cnt++;
      expv = (n > 0) && (n % WIN == 0);
      chk("speed_valid", speed_valid, expv);
      chk("speed_valid4", speed_valid4, expv);
      chk("edge_err4", edge_err4, 0);
      if (expv) begin
        w = n / WIN - 1;
        e = win_edges.exists(w) ? win_edges[w] : 0;
        if (e > 65535) e = 65535;
        chk("speed", speed, e);
      end
    end
  end

  task automatic drive_step(input bit fwd, input int hold);
    int k;
    phase = fwd ? (phase + 1) % 4 : (phase + 3) % 4;
    {sa, sb} = gray[phase];
    k = (n + LAT - 1) / WIN;
    if (!win_edges.exists(k)) win_edges[k] = 0;
    win_edges[k] = win_edges[k] + 1;
    model_pos = model_pos + (fwd ? 1 : -1);
    model_dir = fwd;
    repeat (hold) @(negedge clk);
  endtask

  task automatic step4(input int hold);
    phase4 = (phase4 + 1) % 4;
    {sa4, sb4} = gray[phase4];
    repeat (hold) @(negedge clk);
  endtask

  task automatic chk_pos(input string tag);
    chk(tag, position, $unsigned(model_pos));
    chk({tag, "_dir"}, dir, model_dir);
  endtask

  initial begin
    int e0, t;
    bit d;
    gray[0] = Q00; gray[1] = Q01; gray[2] = Q11; gray[3] = Q10;

    repeat (3) @(negedge clk);
    chk("rst_position", position, 0);
    chk("rst_dir", dir, 1);
    chk("rst_speed", speed, 0);
    chk("rst_speed_valid", speed_valid, 0);
    chk("rst_edge_err", edge_err, 0);
    mon_on = 1'b1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) drive_step(1'b1, 10);
    chk("fwd8_position", position, 8);
    chk("fwd8_dir", dir, 1);
    chk("fwd8_no_err", err_cnt, 0);

    drive_step(1'b0, LAT - 1);
    chk("lat_before", position, 8);
    @(negedge clk);
    chk("lat_at", position, 7);
    chk("lat_dir", dir, 0);
    repeat (8) @(negedge clk);
    drive_step(1'b0, 10);
    drive_step(1'b0, 10);
    chk("rev3_position", position, 5);
    chk("rev3_dir", dir, 0);

    e0 = err_cnt;
    sa = ~sa;
    repeat (2) @(negedge clk);
    sa = ~sa;
    repeat (12) @(negedge clk);
    chk_pos("glitch");
    chk("glitch_err", err_cnt, e0);

    drive_step(1'b0, 10);
    e0 = err_cnt;
    phase = 2;
    {sa, sb} = gray[phase];
    repeat (12) @(negedge clk);
    chk("both_err_pulse", err_cnt, e0 + 1);
    chk_pos("both");

    for (int i = 0; i < WIN && (n % WIN) != 0; i++) @(negedge clk);
    for (int i = 0; i < 12; i++) drive_step(1'(($urandom & 1)), (i == 11) ? 1 : 8);
    t = 0;
    while (speed_valid !== 1'b1 && t < 150) begin @(negedge clk); t++; end
    chk("speed12_seen", (t < 150), 1);
    chk("speed12", speed, 12);
    @(negedge clk);
    t = 0;
    while (speed_valid !== 1'b1 && t < 150) begin @(negedge clk); t++; end
    chk("idle_seen", (t < 150), 1);
    chk("idle_speed", speed, 0);
    chk_pos("after_speed");

    for (int i = 0; i < 40 && model_pos != 5; i++) drive_step(model_pos < 5, 10);
    chk_pos("pos5");
    drive_step(1'b1, LAT - 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_pos = 0;
    repeat (8) @(negedge clk);
    chk("clear_position", position, 0);
    chk("clear_dir", dir, 1);

    for (int i = 0; i < 20; i++) begin
      d = 1'($urandom_range(0, 1));
      drive_step(d, $urandom_range(8, 16));
      chk_pos("rand");
    end

    for (int i = 0; i < 7; i++) step4(10);
    chk("wrap_pos7", position4, 7);
    step4(10);
    chk("wrap_neg8", position4, 4'h8);
    chk("wrap_dir", dir4, 1);

    drive_step(1'b1, 3);
    reset = 1'b1;
    @(negedge clk);
    win_edges.delete();
    chk("midrst_position", position, 0);
    chk("midrst_dir", dir, 1);
    chk("midrst_speed", speed, 0);
    chk("midrst_edge_err", edge_err, 0);
    chk("midrst_speed4", speed4, 0);
    mon_on = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
